// File: rtl/overture_seq_ctrl_if.sv
// Program-memory fetch bus between the Overture sequencer (master) and program memory (slave).
interface overture_seq_ctrl_if;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/overture_seq_ctrl.sv
// Overture instruction sequencer: owns the PC, fetches one instruction byte per step over a
// req/ack bus, stalls I/O copies until their handshakes are ready, and detects halt
// (jump-to-self) and fetch timeout.
// Optional feature: define OVERTURE_SEQ_SINGLE_STEP_EN to add dbg_step_i, which gates every step.
module overture_seq_ctrl #(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       run_i,
  overture_seq_ctrl_if.master        mem,
  output logic [7:0]                 instr_o,
  output logic                       step_o,
  input  logic                       jump_taken_i,
  input  logic [7:0]                 jump_addr_i,
  input  logic                       in_valid_i,
  output logic                       in_ack_o,
  input  logic                       out_ready_i,
  output logic                       out_valid_o,
  output logic [7:0]                 pc_o,
  output logic                       halted_o,
`ifdef OVERTURE_SEQ_SINGLE_STEP_EN
  input  logic                       dbg_step_i,
`endif
  output logic                       fault_o
);

  typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWaitIo, StHalt, StFault} state_e;

  // Count value seen in the last FETCH cycle that may still be answered.
  localparam logic [7:0] CntLimit = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       step, mem_req;
  logic       rd_in, wr_out, io_ok, dbg_ok;

  // Decode the I/O needs of the held instruction.
  always_comb begin
    rd_in  = (instr_q[7:6] == 2'b10) && (instr_q[5:3] == 3'd6);
    wr_out = (instr_q[7:6] == 2'b10) && (instr_q[2:0] == 3'd6);
    io_ok  = (!rd_in || in_valid_i) && (!wr_out || out_ready_i);
`ifdef OVERTURE_SEQ_SINGLE_STEP_EN
    dbg_ok = dbg_step_i;
`else
    dbg_ok = 1'b1;
`endif
  end

  // Next-state, PC update and strobes.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    mem_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_i) state_d = StFetch;
      end
      StFetch: begin
        mem_req = 1'b1;
        if (mem.mem_ack) begin
          // A late ack on the limit cycle still wins over the timeout.
          instr_d = mem.mem_rdata;
          cnt_d   = 8'd0;
          state_d = StIssue;
        end else if (cnt_q == CntLimit) begin
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StIssue: begin
        // With single-step, stay here until a pulse arrives; the pulse is consumed even if I/O stalls.
        if (dbg_ok) begin
          if (io_ok) step = 1'b1;
          else       state_d = StWaitIo;
        end
      end
      StWaitIo: begin
        if (io_ok) step = 1'b1;
      end
      StHalt, StFault: begin
      end
      default: state_d = StIdle;
    endcase

    if (step) begin
      pc_d = jump_taken_i ? jump_addr_i : pc_q + 8'd1;
      if (jump_taken_i && (jump_addr_i == pc_q)) state_d = StHalt;
      else if (run_i)                            state_d = StFetch;
      else                                       state_d = StIdle;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= 8'h00;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem.mem_req  = mem_req;
  assign mem.mem_addr = mem_req ? pc_q : 8'h00;
  assign instr_o      = instr_q;
  assign step_o       = step;
  assign in_ack_o     = step & rd_in;
  assign out_valid_o  = step & wr_out;
  assign pc_o         = pc_q;
  assign halted_o     = (state_q == StHalt);
  assign fault_o      = (state_q == StFault);

endmodule

// File: tb/tb_overture_seq_ctrl.sv
// Directed bench for overture_seq_ctrl: a ROM/ack responder, an architectural model of the
// committed-instruction stream checked every cycle, and literal checks for timing corners.
module tb_overture_seq_ctrl;
  localparam logic [7:0] ResetPc = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n, run, in_valid, out_ready;
  logic [7:0] instr, jump_addr, pc;
  logic       step, jump_taken, in_ack, out_valid, halted, fault;

  logic [7:0] rom [256];
  logic       jmp_en [256];
  logic [7:0] jmp_tgt [256];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int ack_lat = 0;
  int wait_n = 0;

  overture_seq_ctrl_if mif ();

  assign jump_taken = jmp_en[pc];
  assign jump_addr  = jmp_tgt[pc];

  overture_seq_ctrl #(.RESET_PC(ResetPc), .MEM_TIMEOUT(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .run_i        (run),
    .mem          (mif.master),
    .instr_o      (instr),
    .step_o       (step),
    .jump_taken_i (jump_taken),
    .jump_addr_i  (jump_addr),
    .in_valid_i   (in_valid),
    .in_ack_o     (in_ack),
    .out_ready_i  (out_ready),
    .out_valid_o  (out_valid),
    .pc_o         (pc),
    .halted_o     (halted),
`ifdef OVERTURE_SEQ_SINGLE_STEP_EN
    .dbg_step_i   (1'b1),
`endif
    .fault_o      (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit f_rd(input logic [7:0] i);
    return (i[7:6] == 2'b10) && (i[5:3] == 3'd6);
  endfunction

  function automatic bit f_wr(input logic [7:0] i);
    return (i[7:6] == 2'b10) && (i[2:0] == 3'd6);
  endfunction

  // Program memory: ack after ack_lat extra request cycles, data from the ROM.
  always @(negedge clk) begin
    if (mif.mem_req) begin
      if (wait_n >= ack_lat) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = rom[mif.mem_addr];
      end else begin
        mif.mem_ack = 1'b0;
      end
      wait_n++;
    end else begin
      mif.mem_ack = 1'b0;
      wait_n      = 0;
    end
  end

  // Architectural model: the PC and halt flag follow the program from the ROM and jump tables.
  bit         chk_en = 1'b0;
  logic [7:0] m_pc;
  bit         m_halted;
  logic [7:0] ck_instr;

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("pc", 32'(pc), 32'(m_pc));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("fault", 32'(fault), 32'd0);
      if (mif.mem_req) chk("mem_addr", 32'(mif.mem_addr), 32'(m_pc));
      if (m_halted) chk("halt_quiet", 32'({mif.mem_req, step}), 32'd0);
      if (step) begin
        ck_instr = rom[m_pc];
        chk("instr", 32'(instr), 32'(ck_instr));
        chk("in_ack", 32'(in_ack), 32'(f_rd(ck_instr)));
        chk("out_valid", 32'(out_valid), 32'(f_wr(ck_instr)));
        chk("io_ready", 32'((!f_rd(ck_instr) || in_valid) && (!f_wr(ck_instr) || out_ready)), 32'd1);
        if (jmp_en[m_pc]) begin
          if (jmp_tgt[m_pc] == m_pc) m_halted = 1'b1;
          m_pc = jmp_tgt[m_pc];
        end else begin
          m_pc = m_pc + 8'd1;
        end
      end else begin
        chk("no_step_strobes", 32'({in_ack, out_valid}), 32'd0);
      end
    end
  end

  task automatic wait_step(output logic [7:0] p, output int c);
    bit got = 1'b0;
    p = 8'h00;
    c = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      #3;
      if (step) begin
        got = 1'b1;
        p   = pc;
        c   = cyc;
      end
    end
    if (!got) begin
      total_cnt++;
      $display("FAIL step_wait: no step within 60 cycles, expected one (t=%0t)", $time);
    end
  endtask

  task automatic model_reset();
    m_pc     = ResetPc;
    m_halted = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] p;
    int         c, prev_c, nreq;
    logic       any;

    for (int i = 0; i < 256; i++) begin
      rom[i]     = 8'(i) & 8'h3F;
      jmp_en[i]  = 1'b0;
      jmp_tgt[i] = 8'h00;
    end
    rom[8'h20] = 8'hB6;  // copy in -> out
    rom[8'h21] = 8'h86;  // copy r0 -> out
    rom[8'h22] = 8'hB0;  // copy in -> r0
    jmp_en[8'h04] = 1'b1; jmp_tgt[8'h04] = 8'hFF;
    jmp_en[8'h22] = 1'b1; jmp_tgt[8'h22] = 8'h10;
    jmp_en[8'h10] = 1'b1; jmp_tgt[8'h10] = 8'h10;

    mif.mem_ack = 1'b0; mif.mem_rdata = 8'h00;
    rst_n = 1'b0; run = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    chk("reset_outs", 32'({mif.mem_req, mif.mem_addr, instr, step, in_ack, out_valid, halted, fault}),
        32'd0);
    chk("reset_pc", 32'(pc), 32'h00);
    model_reset();
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Straight-line code, one-cycle ack: a step every second cycle.
    prev_c = 0;
    for (int k = 0; k < 5; k++) begin
      wait_step(p, c);
      chk("t1_step_pc", 32'(p), 32'(k));
      if (k > 0) chk("t1_step_gap", 32'(c - prev_c), 32'd2);
      prev_c = c;
    end

    // pc 4 jumps to FF, which then wraps to 00; run falls mid-fetch of 00.
    wait_step(p, c);
    chk("t2_step_ff", 32'(p), 32'hFF);
    @(negedge clk);
    run = 1'b0;
    #3;
    chk("t2_wrap_fetch", 32'({mif.mem_req, mif.mem_addr}), 32'h100);
    wait_step(p, c);
    chk("t2_step_after_run_low", 32'(p), 32'h00);
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      any = any | mif.mem_req | step;
    end
    chk("t2_idle_quiet", 32'(any), 32'd0);
    chk("t2_idle_pc", 32'(pc), 32'h01);

    // I/O stalls: B6 waits for in_valid, 86 waits for out_ready.
    jmp_en[8'h01] = 1'b1; jmp_tgt[8'h01] = 8'h20;
    @(negedge clk);
    run = 1'b1;
    wait_step(p, c);
    chk("t3_jump_step", 32'(p), 32'h01);
    @(negedge clk);
    #3;
    chk("t3_fetch_20", 32'({mif.mem_req, mif.mem_addr}), 32'h120);
    any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      any = any | step | in_ack | out_valid;
    end
    chk("t3_stall_in", 32'(any), 32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    #3;
    chk("t3_release_in", 32'({step, in_ack, out_valid}), 32'b111);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #3;
    any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #3;
      any = any | step;
    end
    chk("t3_stall_out", 32'(any), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    #3;
    chk("t3_release_out", 32'({step, in_ack, out_valid}), 32'b101);
    @(negedge clk);
    in_valid = 1'b1;

    // 22 jumps to 10, 10 jumps to itself: halt.
    any = 1'b0;
    for (int i = 0; i < 20 && !any; i++) begin
      @(negedge clk);
      #3;
      any = halted;
    end
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_pc", 32'(pc), 32'h10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #3;
      chk("t4_no_req", 32'({mif.mem_req, step}), 32'd0);
    end

    // Asynchronous reset while stalled in WAIT_IO.
    chk_en = 1'b0;
    rst_n = 1'b0;
    jmp_en[8'h00] = 1'b1; jmp_tgt[8'h00] = 8'h20;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    wait_step(p, c);
    chk("t6_first_step", 32'(p), 32'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #3;
    end
    chk("t6_stalled", 32'({step, pc}), 32'h020);
    chk("t6_pre_instr", 32'(instr), 32'hB6);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_async_outs", 32'({mif.mem_req, mif.mem_addr, instr, step, in_ack, out_valid, halted,
        fault}), 32'd0);
    chk("t6_async_pc", 32'(pc), 32'(ResetPc));

    // Memory never answers: fault after exactly 16 request cycles.
    jmp_en[8'h00] = 1'b0;
    ack_lat = 1000;
    @(negedge clk);
    rst_n = 1'b1;
    nreq = 0;
    any = 1'b0;
    for (int i = 0; i < 40 && !any; i++) begin
      @(negedge clk);
      #3;
      if (mif.mem_req) nreq++;
      any = fault;
    end
    chk("t5_req_cycles", 32'(nreq), 32'd16);
    chk("t5_fault", 32'(fault), 32'd1);
    chk("t5_fault_quiet", 32'({mif.mem_req, step}), 32'd0);

    // Ack on the 16th request cycle beats the timeout.
    rst_n = 1'b0;
    ack_lat = 15;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    nreq = 0;
    any = 1'b0;
    for (int i = 0; i < 40 && !any; i++) begin
      @(negedge clk);
      #3;
      if (mif.mem_req) nreq++;
      any = step;
    end
    chk("t5b_req_cycles", 32'(nreq), 32'd16);
    chk("t5b_step_pc", 32'({step, pc}), 32'h100);
    chk("t5b_no_fault", 32'(fault), 32'd0);
    @(negedge clk);
    run = 1'b0;
    #3;
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
